// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a first-word-fall-through queue RAM.
// Optional build macro FIFO_ERR_STICKY_EN: overflow/underflow errors hold at 1 until reset_L=0.
module fifo_ctrl #(
  parameter int DATA_SIZE       = 10,
  parameter int MAIN_QUEUE_SIZE = 8
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       push,
  input  logic                       pop,
  input  logic [MAIN_QUEUE_SIZE:0]   umbral_alto,
  input  logic [MAIN_QUEUE_SIZE:0]   umbral_bajo,
  output logic                       write,
  output logic                       read,
  output logic [MAIN_QUEUE_SIZE-1:0] wr_ptr,
  output logic [MAIN_QUEUE_SIZE-1:0] rd_ptr,
  output logic [MAIN_QUEUE_SIZE:0]   fifo_count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam logic [MAIN_QUEUE_SIZE:0] Depth = {1'b1, {MAIN_QUEUE_SIZE{1'b0}}};

  // DATA_SIZE only sizes the companion RAM; this controller never handles data words.
  if (DATA_SIZE < 1) begin : g_data_size_invalid
  end

  logic [MAIN_QUEUE_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAIN_QUEUE_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAIN_QUEUE_SIZE:0]   count_q, count_d;
  logic full_q, full_d, empty_q, empty_d;
  logic afull_q, afull_d, aempty_q, aempty_d;
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Gating with reset_L keeps the RAM untouched while reset is held.
  assign write = push & ~full_q  & reset_L;
  assign read  = pop  & ~empty_q & reset_L;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (read)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({write, read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flags come from the next-state count so they move on the same edge as fifo_count.
    full_d   = (count_d == Depth);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= umbral_alto);
    aempty_d = (count_d <= umbral_bajo);

`ifdef FIFO_ERR_STICKY_EN
    ovf_d = ovf_q | (push & full_q);
    udf_d = udf_q | (pop  & empty_q);
`else
    ovf_d = push & full_q;
    udf_d = pop  & empty_q;
`endif
  end

  // NOTE: only control state is reset; the RAM contents are deliberately left as they are.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking '<=' so every register samples the pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign wr_ptr        = wr_ptr_q;
  assign rd_ptr        = rd_ptr_q;
  assign fifo_count    = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign almost_full   = afull_q;
  assign almost_empty  = aempty_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;

endmodule
